// File: rtl/biriscv_csr_wb_pipe.sv
// biriscv_csr_wb_pipe
//   Carries CSR-unit E1 results through E2 into writeback for the integer
//   lane that hosts the CSR unit. Merges interrupt, CSR-unit and memory
//   exceptions into one WB exception, drives the CSR regfile writeback and
//   the integer regfile result for CSR reads, and squashes the younger E2
//   entry while WB commits an exception.
//
//   Optional feature macro: BIRISCV_CSR_WB_HAZARD_EN
//     defined   -> csr_busy_o flags a CSR write pending in E2 or WB
//     undefined -> csr_busy_o is tied to 0

`ifndef EXCEPTION_INTERRUPT
`define EXCEPTION_MISALIGNED_FETCH    6'h10
`define EXCEPTION_FAULT_FETCH         6'h11
`define EXCEPTION_ILLEGAL_INSTRUCTION 6'h12
`define EXCEPTION_BREAKPOINT          6'h13
`define EXCEPTION_MISALIGNED_LOAD     6'h14
`define EXCEPTION_FAULT_LOAD          6'h15
`define EXCEPTION_MISALIGNED_STORE    6'h16
`define EXCEPTION_FAULT_STORE         6'h17
`define EXCEPTION_ECALL               6'h18
`define EXCEPTION_ECALL_U             6'h18
`define EXCEPTION_ECALL_S             6'h19
`define EXCEPTION_ECALL_H             6'h1a
`define EXCEPTION_ECALL_M             6'h1b
`define EXCEPTION_PAGE_FAULT_INST     6'h1c
`define EXCEPTION_PAGE_FAULT_LOAD     6'h1d
`define EXCEPTION_PAGE_FAULT_STORE    6'h1f
`define EXCEPTION_INTERRUPT           6'h20
`define EXCEPTION_ERET_U              6'h30
`define EXCEPTION_ERET_S              6'h31
`define EXCEPTION_ERET_H              6'h32
`define EXCEPTION_ERET_M              6'h33
`define EXCEPTION_FENCE               6'h34
`endif

module biriscv_csr_wb_pipe #(
  parameter int SUPPORT_INTR = 1,
  parameter int EXCEPTION_W  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_e1_i,
  input  logic [31:0]            pc_e1_i,
  input  logic [31:0]            opcode_e1_i,
  input  logic [31:0]            csr_value_e1_i,
  input  logic                   csr_write_e1_i,
  input  logic [31:0]            csr_wdata_e1_i,
  input  logic [EXCEPTION_W-1:0] csr_exception_e1_i,
  input  logic [EXCEPTION_W-1:0] mem_exception_e2_i,
  input  logic [31:0]            mem_addr_e2_i,
  input  logic                   take_interrupt_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   csr_writeback_write_o,
  output logic [11:0]            csr_writeback_waddr_o,
  output logic [31:0]            csr_writeback_wdata_o,
  output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
  output logic [31:0]            csr_writeback_exception_pc_o,
  output logic [31:0]            csr_writeback_exception_addr_o,
  output logic                   rd_valid_o,
  output logic [4:0]             rd_idx_o,
  output logic [31:0]            rd_value_o,
  output logic                   squash_o,
  output logic                   csr_busy_o
);

  // E2 stage state
  logic                   e2_valid_q;
  logic [31:0]            e2_pc_q;
  logic [11:0]            e2_csr_addr_q;
  logic [4:0]             e2_rd_q;
  logic [31:0]            e2_csr_value_q;
  logic                   e2_csr_write_q;
  logic [31:0]            e2_csr_wdata_q;
  logic [EXCEPTION_W-1:0] e2_exception_q;

  // WB stage state, drives the outputs directly
  logic                   wb_write_q;
  logic [11:0]            wb_waddr_q;
  logic [31:0]            wb_wdata_q;
  logic [EXCEPTION_W-1:0] wb_exception_q;
  logic [31:0]            wb_exc_pc_q;
  logic [31:0]            wb_exc_addr_q;
  logic                   wb_rd_valid_q;
  logic [4:0]             wb_rd_idx_q;
  logic [31:0]            wb_rd_value_q;
  logic                   wb_squash_q;

  logic                   wb_load;
  logic                   e2_kill;
  logic [EXCEPTION_W-1:0] exc_next;
  logic [31:0]            tval_next;

  // Only the CSR address and rd fields of the opcode are needed here
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^{opcode_e1_i[19:12], opcode_e1_i[6:0]};

  // A redirect or a committing WB exception kills whatever sits in E2
  assign e2_kill = flush_i | wb_squash_q;
  assign wb_load = e2_valid_q & ~stall_i & ~e2_kill;

  // Exception merge: interrupt, then CSR-unit, then memory fault
  always_comb begin
    exc_next  = '0;
    tval_next = '0;
    if ((SUPPORT_INTR != 0) && take_interrupt_i) begin
      exc_next = EXCEPTION_W'(`EXCEPTION_INTERRUPT);
    end else if (e2_exception_q != '0) begin
      exc_next  = e2_exception_q;
      tval_next = e2_csr_value_q;
    end else if (mem_exception_e2_i != '0) begin
      exc_next  = mem_exception_e2_i;
      tval_next = mem_addr_e2_i;
    end
  end

  // E2 register: load from E1 when not stalled, otherwise hold (kill still applies)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e2_valid_q     <= 1'b0;
      e2_pc_q        <= '0;
      e2_csr_addr_q  <= '0;
      e2_rd_q        <= '0;
      e2_csr_value_q <= '0;
      e2_csr_write_q <= 1'b0;
      e2_csr_wdata_q <= '0;
      e2_exception_q <= '0;
    end else if (!stall_i) begin
      e2_valid_q     <= valid_e1_i & ~e2_kill;
      e2_pc_q        <= pc_e1_i;
      e2_csr_addr_q  <= opcode_e1_i[31:20];
      e2_rd_q        <= opcode_e1_i[11:7];
      e2_csr_value_q <= csr_value_e1_i;
      e2_csr_write_q <= csr_write_e1_i;
      e2_csr_wdata_q <= csr_wdata_e1_i;
      e2_exception_q <= csr_exception_e1_i;
    end else if (e2_kill) begin
      e2_valid_q <= 1'b0;
    end
  end

  // WB register: capture E2 with the merged exception, or take an all-zero bubble
  always_ff @(posedge clk_i) begin
    if (rst_i || !wb_load) begin
      wb_write_q     <= 1'b0;
      wb_waddr_q     <= '0;
      wb_wdata_q     <= '0;
      wb_exception_q <= '0;
      wb_exc_pc_q    <= '0;
      wb_exc_addr_q  <= '0;
      wb_rd_valid_q  <= 1'b0;
      wb_rd_idx_q    <= '0;
      wb_rd_value_q  <= '0;
      wb_squash_q    <= 1'b0;
    end else begin
      wb_exception_q <= exc_next;
      wb_exc_pc_q    <= e2_pc_q;
      wb_exc_addr_q  <= tval_next;
      if (exc_next != '0) begin
        wb_write_q    <= 1'b0;
        wb_waddr_q    <= '0;
        wb_wdata_q    <= '0;
        wb_rd_valid_q <= 1'b0;
        wb_rd_idx_q   <= '0;
        wb_rd_value_q <= '0;
        wb_squash_q   <= 1'b1;
      end else begin
        wb_write_q    <= e2_csr_write_q;
        wb_waddr_q    <= e2_csr_addr_q;
        wb_wdata_q    <= e2_csr_wdata_q;
        wb_rd_valid_q <= (e2_rd_q != 5'd0);
        wb_rd_idx_q   <= e2_rd_q;
        wb_rd_value_q <= e2_csr_value_q;
        wb_squash_q   <= 1'b0;
      end
    end
  end

  assign csr_writeback_write_o          = wb_write_q;
  assign csr_writeback_waddr_o          = wb_waddr_q;
  assign csr_writeback_wdata_o          = wb_wdata_q;
  assign csr_writeback_exception_o      = wb_exception_q;
  assign csr_writeback_exception_pc_o   = wb_exc_pc_q;
  assign csr_writeback_exception_addr_o = wb_exc_addr_q;
  assign rd_valid_o                     = wb_rd_valid_q;
  assign rd_idx_o                       = wb_rd_idx_q;
  assign rd_value_o                     = wb_rd_value_q;
  assign squash_o                       = wb_squash_q;

`ifdef BIRISCV_CSR_WB_HAZARD_EN
  // Raw CSR-write request of the WB entry, kept even if the entry excepts
  logic wb_csr_write_q;

  // Track the write request alongside the WB entry
  always_ff @(posedge clk_i) begin
    if (rst_i || !wb_load) begin
      wb_csr_write_q <= 1'b0;
    end else begin
      wb_csr_write_q <= e2_csr_write_q;
    end
  end

  assign csr_busy_o = (e2_valid_q & e2_csr_write_q) | wb_csr_write_q;
`else
  assign csr_busy_o = 1'b0;
`endif

endmodule

// File: doc/biriscv_csr_wb_pipe.md
Name: biriscv_csr_wb_pipe

Overview:
- Carries CSR-unit E1 results through E2 into the writeback (WB) stage, in the integer issue lane that hosts the CSR unit.
- Merges the CSR-unit E1 exception, the E2 memory-fault exception and the interrupt request into one WB exception.
- Drives the CSR regfile write/exception inputs (csr_writeback_*) and the integer-regfile result for CSR reads.
- Squashes the younger E2 entry when WB commits an exception.

Parameters:
- SUPPORT_INTR, 1, 1 = take_interrupt_i is injected at E2->WB; 0 = take_interrupt_i is ignored.
- EXCEPTION_W, 6, exception code width; codes are the `EXCEPTION_* defines.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_e1_i  in  1  E1 holds a valid CSR-lane instruction
- pc_e1_i  in  32  PC of the E1 instruction
- opcode_e1_i  in  32  E1 opcode; [31:20] is the CSR address, [11:7] is rd
- csr_value_e1_i  in  32  CSR read value, or the faulting opcode for illegal instructions
- csr_write_e1_i  in  1  CSR write requested
- csr_wdata_e1_i  in  32  CSR write data
- csr_exception_e1_i  in  6  E1 exception code, 0 = none
- mem_exception_e2_i  in  6  E2 memory-fault code, 0 = none
- mem_addr_e2_i  in  32  E2 faulting address
- take_interrupt_i  in  1  interrupt pending
- stall_i  in  1  E2 hold
- flush_i  in  1  kill the E2 entry (younger than a redirect)
- csr_writeback_write_o  out  1  CSR regfile write strobe
- csr_writeback_waddr_o  out  12  CSR regfile write address
- csr_writeback_wdata_o  out  32  CSR regfile write data
- csr_writeback_exception_o  out  6  WB exception code
- csr_writeback_exception_pc_o  out  32  PC of the excepting instruction
- csr_writeback_exception_addr_o  out  32  tval value
- rd_valid_o  out  1  integer regfile write enable
- rd_idx_o  out  5  integer regfile destination
- rd_value_o  out  32  integer regfile write data
- squash_o  out  1  WB exception is active; younger stages are flushed
- csr_busy_o  out  1  CSR write is pending in E2 or WB (optional feature)

Behaviour:
- Two register stages, E2 and WB. All state and outputs are registered.
- Latency: E1 input to WB output is 2 cycles when there is no stall.
- Reset (synchronous): E2.valid = 0, WB.valid = 0. Every output is 0, including squash_o and csr_busy_o.
- E2 load, when !stall_i:
  - E2 captures all E1 inputs.
  - E2.valid = valid_e1_i & !flush_i & !squash_o.
- E2 hold, when stall_i: E2 keeps its contents, except that flush_i or squash_o still clears E2.valid.
- WB load:
  - When !stall_i and E2.valid: WB captures E2.
  - Otherwise WB takes a bubble (valid = 0). A stall never repeats a WB strobe.
- Exception merge at E2->WB, priority high to low:
  1. Interrupt: SUPPORT_INTR & take_interrupt_i -> `EXCEPTION_INTERRUPT, tval = 0.
  2. CSR: csr_exception_e1 != 0 -> that code, tval = csr_value.
  3. Memory: mem_exception_e2_i != 0 -> that code, tval = mem_addr_e2_i.
  4. Otherwise: code 0, tval = 0.
- exception_pc_o = the instruction PC for every source. An interrupt resumes at that PC and the instruction is not retired.
- Any nonzero WB exception, including `EXCEPTION_FENCE and the ERET codes:
  - csr_writeback_write_o = 0 and rd_valid_o = 0.
  - squash_o = 1 for exactly that WB cycle.
- No exception:
  - csr_writeback_write_o = csr_write & valid.
  - waddr = opcode[31:20]; wdata = csr_wdata.
  - rd_valid_o = valid & (rd != 0); rd_value_o = csr_value.
- Bubble / invalid WB: every output is 0, including waddr = 0. The CSR regfile ignores address 0.
- flush_i and stall_i in the same cycle: flush wins. E2 goes invalid and WB takes a bubble.
- squash_o and a new valid_e1_i in the same cycle: the E1 entry is dropped (E2.valid = 0).
- Reset mid-instruction discards both stages with no partial strobe. Reset overrides stall_i.

Optional Feature:
- Macro: BIRISCV_CSR_WB_HAZARD_EN.
- Defined: csr_busy_o = (E2.valid & E2.csr_write) | (WB.valid & WB.csr_write). Registered-state OR, same cycle. Issue uses it to hold CSR reads.
- Undefined: csr_busy_o is tied to 0 and no logic is generated.

Test Plan:
- csrrw, no exception: E1 has pc=0x80000010, opcode[31:20]=0x340, rd=5, csr_value=0x11, csr_write=1, wdata=0xA5 -> at cycle +2: write=1, waddr=0x340, wdata=0xA5, rd_valid=1, rd_idx=5, rd_value=0x11, exception=0. Next cycle all outputs = 0.
- Illegal instruction: csr_exception=`EXCEPTION_ILLEGAL_INSTRUCTION, csr_value=0xDEADBEEF, pc=0x200 -> exception=ILLEGAL, exception_pc=0x200, exception_addr=0xDEADBEEF, write=0, rd_valid=0, squash_o=1 for 1 cycle. The following E1 instruction never reaches WB.
- Load fault: mem_exception_e2=`EXCEPTION_FAULT_LOAD, mem_addr=0x1000_0004 -> exception_addr=0x1000_0004. With csr_exception=ECALL also set, the ECALL code wins.
- Interrupt: take_interrupt_i=1 while E2 holds pc=0x300 with csr_write=1 -> exception=`EXCEPTION_INTERRUPT, exception_pc=0x300, write=0, addr=0. With SUPPORT_INTR=0 -> a normal CSR write occurs.
- Stall/flush: 3 cycles of stall_i on a valid E2 -> WB shows 3 bubbles, then one write strobe. flush_i together with stall_i -> no strobe. Assert rst_i during the stall -> all outputs 0 on the next edge.
- With BIRISCV_CSR_WB_HAZARD_EN: csr_busy_o=1 for the 2 cycles the write is in E2/WB and 0 otherwise. Without the macro: stays 0.
